// File: rtl/ofm_wr_burst_ctrl_if.sv
// ============================================================================
//  Module      : ofm_wr_burst_ctrl_if
//  Description : OFM beat stream plus AW/W/B write-channel bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ofm_wr_burst_ctrl_if #(
   parameter int DATA_WIDTH = 512
);
   logic [DATA_WIDTH-1:0] s_tdata;
   logic                  s_valid;
   logic                  s_ready;

   logic                  aw_valid;
   logic                  aw_ready;
   logic [63:0]           aw_addr;
   logic [7:0]            aw_len;

   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_valid;
   logic                  w_ready;
   logic                  w_last;

   logic                  b_valid;
   logic [1:0]            b_resp;
   logic                  b_ready;

   // Controller side: consumes the stream, masters the write channels.
   modport master (
      input  s_tdata, s_valid,
      output s_ready,
      output aw_valid, aw_addr, aw_len,
      input  aw_ready,
      output w_data, w_valid, w_last,
      input  w_ready,
      input  b_valid, b_resp,
      output b_ready
   );

   modport slave (
      output s_tdata, s_valid,
      input  s_ready,
      input  aw_valid, aw_addr, aw_len,
      output aw_ready,
      input  w_data, w_valid, w_last,
      output w_ready,
      output b_valid, b_resp,
      input  b_ready
   );
endinterface

`default_nettype wire

// File: rtl/ofm_wr_burst_ctrl.sv
// ============================================================================
//  Module      : ofm_wr_burst_ctrl
//  Description : Splits one OFM write job into 4 KB-safe bursts, issues AW/W
//                and retires the job once every B response has returned.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ofm_wr_burst_ctrl #(
   parameter int DATA_WIDTH   = 512,
   parameter int BURST_LENGTH = 64,
   parameter int MAX_OUTST    = 8
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        op_start,
   input  wire logic [63:0] job_addr,
   input  wire logic [63:0] job_size,
   ofm_wr_burst_ctrl_if.master bus,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // Beat geometry; DATA_WIDTH is expected to be a power of two >= 16.
   localparam int ADDR_LSB   = $clog2(DATA_WIDTH / 8);
   localparam int BEATW      = 64 - ADDR_LSB;
   localparam int PAGE_BEATS = 4096 >> ADDR_LSB;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_AW_REQ = 3'd1;
   localparam logic [2:0] ST_W_DATA = 3'd2;
   localparam logic [2:0] ST_WAIT_B = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [63:0]      r_cur_addr;
   logic [BEATW-1:0] r_rem_beats;
   logic [7:0]       r_outst;
   logic [8:0]       r_beat_cnt;
   logic [8:0]       r_burst;

   logic [BEATW-1:0] w_job_beats;
   logic [8:0]       w_to_page;
   logic [8:0]       w_rem_cap;
   logic [8:0]       w_burst;
   logic             w_in_aw;
   logic             w_in_w;
   logic             w_aw_valid;
   logic             w_aw_hs;
   logic             w_beat;
   logic             w_last_beat;
   logic             w_b_take;
   logic             w_start;
   logic             w_unused_addr_lsb;

   // Base address is beat aligned, so its low bits carry no information.
   assign w_unused_addr_lsb = ^job_addr[ADDR_LSB-1:0];

   assign w_job_beats = BEATW'(job_size >> ADDR_LSB)
                      + BEATW'(|job_size[ADDR_LSB-1:0]);

   // Burst size: remaining beats, capped by burst length and by the 4 KB page.
   assign w_to_page = 9'(PAGE_BEATS) - 9'(r_cur_addr[11:ADDR_LSB]);
   assign w_rem_cap = (r_rem_beats < BEATW'(BURST_LENGTH)) ? 9'(r_rem_beats)
                                                           : 9'(BURST_LENGTH);
   assign w_burst   = (w_rem_cap < w_to_page) ? w_rem_cap : w_to_page;

   assign w_start     = (r_state == ST_IDLE) && op_start;
   assign w_in_aw     = (r_state == ST_AW_REQ);
   assign w_in_w      = (r_state == ST_W_DATA);
   assign w_aw_valid  = w_in_aw && (r_outst < 8'(MAX_OUTST));
   assign w_aw_hs     = w_aw_valid && bus.aw_ready;
   assign w_beat      = w_in_w && bus.s_valid && bus.w_ready;
   assign w_last_beat = w_beat && (r_beat_cnt == 9'd1);
   assign w_b_take    = bus.b_valid && (r_outst != 8'd0);

   assign bus.aw_valid = w_aw_valid;
   assign bus.aw_addr  = w_in_aw ? r_cur_addr : 64'd0;
   assign bus.aw_len   = w_in_aw ? 8'(w_burst - 9'd1) : 8'd0;
   assign bus.w_data   = bus.s_tdata;
   assign bus.w_valid  = w_in_w && bus.s_valid;
   assign bus.s_ready  = w_in_w && bus.w_ready;
   assign bus.w_last   = w_in_w && (r_beat_cnt == 9'd1);
   assign bus.b_ready  = rst_n;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (op_start) begin
               w_state_nxt = (w_job_beats == '0) ? ST_DONE : ST_AW_REQ;
            end
         end
         ST_AW_REQ: begin
            if (w_aw_hs) begin
               w_state_nxt = ST_W_DATA;
            end
         end
         ST_W_DATA: begin
            if (w_last_beat) begin
               w_state_nxt = (r_rem_beats == BEATW'(r_burst)) ? ST_WAIT_B
                                                              : ST_AW_REQ;
            end
         end
         ST_WAIT_B: begin
            if (r_outst == 8'd0) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cur_addr  <= 64'd0;
         r_rem_beats <= '0;
         r_beat_cnt  <= 9'd0;
         r_burst     <= 9'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         done    <= (w_state_nxt == ST_DONE);

         if (w_start) begin
            r_cur_addr  <= {job_addr[63:ADDR_LSB], {ADDR_LSB{1'b0}}};
            r_rem_beats <= w_job_beats;
            busy        <= 1'b1;
         end else if (r_state == ST_DONE) begin
            busy <= 1'b0;
         end

         if (w_aw_hs) begin
            r_burst    <= w_burst;
            r_beat_cnt <= w_burst;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt - 9'd1;
         end

         // Advance the job only once the whole burst has been written.
         if (w_last_beat) begin
            r_cur_addr  <= r_cur_addr + (64'(r_burst) << ADDR_LSB);
            r_rem_beats <= r_rem_beats - BEATW'(r_burst);
         end
      end
   end

   // Outstanding-burst accounting runs in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outst <= 8'd0;
      end else begin
         case ({w_aw_hs, w_b_take})
            2'b10:   r_outst <= r_outst + 8'd1;
            2'b01:   r_outst <= r_outst - 8'd1;
            default: r_outst <= r_outst;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (w_start) begin
         err <= 1'b0;
      end else if (bus.b_valid && (bus.b_resp != 2'b00)) begin
         err <= 1'b1;
      end
   end

endmodule

`default_nettype wire
